// File: rtl/full_adder_unit_if.sv
// Operand/result bundle for full_adder_unit.
//   master : drives in_valid, a, b, c; observes sum, cout, ovf, out_valid
//   slave  : the adder side; samples operands and drives the registered result
interface full_adder_unit_if #(
  parameter int unsigned WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid, a, b, c,
    input  sum, cout, ovf, out_valid
  );

  modport slave (
    input  in_valid, a, b, c,
    output sum, cout, ovf, out_valid
  );
endinterface

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder built from 1-bit full-adder cells.
// {cout, sum} = a + b + c, with ovf flagging two's-complement overflow
// (carry into MSB XOR carry out of MSB). One cycle of latency; a result
// is produced for every cycle in_valid is high, with no backpressure.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (priority over in_valid)
//   bus  : slave side of full_adder_unit_if (operands in, registered result out)
module full_adder_unit #(
  parameter int unsigned WIDTH = 1
) (
  input logic               clk,
  input logic               rst,
  full_adder_unit_if.slave  bus
);

  logic [WIDTH-1:0] sum_q,  sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q,  ovf_d;
  logic             out_valid_q, out_valid_d;

  // k[i] is the carry into cell i; k[WIDTH] is the carry out of the MSB cell.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s;

  always_comb begin
    k    = '0;
    s    = '0;
    k[0] = bus.c;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = bus.a[i] ^ bus.b[i] ^ k[i];
      k[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & k[i]) | (bus.b[i] & k[i]);
    end
  end

  // Hold on idle cycles; selecting the old value keeps don't-care operands
  // out of the result registers.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d  = s;
      cout_d = k[WIDTH];
      ovf_d  = k[WIDTH-1] ^ k[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_unit.sv
// Scoreboard bench for full_adder_unit at WIDTH=1 and WIDTH=4.
module tb_full_adder_unit;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;

  int checks = 0;
  int passed = 0;

  exp_t q1[$];
  exp_t q4[$];

  full_adder_unit_if #(.WIDTH(1)) if1 ();
  full_adder_unit_if #(.WIDTH(4)) if4 ();

  full_adder_unit #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  full_adder_unit #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare every presented result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (if1.out_valid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL w1_unexpected_result: out_valid=1, expected no result (t=%0t)", $time);
      end else begin
        e = q1.pop_front();
        check("w1_sum",  {31'b0, if1.sum}, {28'b0, e.sum});
        check("w1_cout", {31'b0, if1.cout}, {31'b0, e.cout});
        check("w1_ovf",  {31'b0, if1.ovf}, {31'b0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if4.out_valid === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        $display("FAIL w4_unexpected_result: out_valid=1, expected no result (t=%0t)", $time);
      end else begin
        e = q4.pop_front();
        check("w4_sum",  {28'b0, if4.sum}, {28'b0, e.sum});
        check("w4_cout", {31'b0, if4.cout}, {31'b0, e.cout});
        check("w4_ovf",  {31'b0, if4.ovf}, {31'b0, e.ovf});
      end
    end
  end

  // Hand-computed tables.
  // WIDTH=1, {a,b,c} = 0..7: sum, cout, ovf (= c ^ cout)
  logic [7:0] w1_sum  = 8'b1001_0110; // bit i = sum for index i
  logic [7:0] w1_cout = 8'b1110_1000;
  logic [7:0] w1_ovf  = 8'b0100_0010;

  // WIDTH=4 directed vectors: a, b, c, sum, cout, ovf
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec4_t;

  vec4_t v4[6] = '{
    '{a: 4'd15, b: 4'd0,  c: 1'b1, sum: 4'd0,  cout: 1'b1, ovf: 1'b0},
    '{a: 4'd15, b: 4'd15, c: 1'b1, sum: 4'd15, cout: 1'b1, ovf: 1'b0},
    '{a: 4'd7,  b: 4'd1,  c: 1'b0, sum: 4'd8,  cout: 1'b0, ovf: 1'b1},
    '{a: 4'd8,  b: 4'd8,  c: 1'b0, sum: 4'd0,  cout: 1'b1, ovf: 1'b1},
    '{a: 4'd3,  b: 4'd4,  c: 1'b0, sum: 4'd7,  cout: 1'b0, ovf: 1'b0},
    '{a: 4'd9,  b: 4'd6,  c: 1'b1, sum: 4'd0,  cout: 1'b1, ovf: 1'b0}
  };

  // Mid-stream reset stream; entry 2 is presented with rst=1 and discarded.
  vec4_t ms[5] = '{
    '{a: 4'd1,  b: 4'd2, c: 1'b0, sum: 4'd3, cout: 1'b0, ovf: 1'b0},
    '{a: 4'd4,  b: 4'd4, c: 1'b1, sum: 4'd9, cout: 1'b0, ovf: 1'b1},
    '{a: 4'd5,  b: 4'd5, c: 1'b0, sum: 4'd0, cout: 1'b0, ovf: 1'b0},
    '{a: 4'd2,  b: 4'd3, c: 1'b1, sum: 4'd6, cout: 1'b0, ovf: 1'b0},
    '{a: 4'd15, b: 4'd1, c: 1'b0, sum: 4'd0, cout: 1'b1, ovf: 1'b0}
  };

  task automatic drive4(input vec4_t v, input logic push);
    if4.in_valid = 1'b1;
    if4.a        = v.a;
    if4.b        = v.b;
    if4.c        = v.c;
    if (push) q4.push_back('{sum: v.sum, cout: v.cout, ovf: v.ovf});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_w1_sum"},   {31'b0, if1.sum},       32'd0);
    check({tag, "_w1_cout"},  {31'b0, if1.cout},      32'd0);
    check({tag, "_w1_ovf"},   {31'b0, if1.ovf},       32'd0);
    check({tag, "_w1_valid"}, {31'b0, if1.out_valid}, 32'd0);
    check({tag, "_w4_sum"},   {28'b0, if4.sum},       32'd0);
    check({tag, "_w4_cout"},  {31'b0, if4.cout},      32'd0);
    check({tag, "_w4_ovf"},   {31'b0, if4.ovf},       32'd0);
    check({tag, "_w4_valid"}, {31'b0, if4.out_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0] abc;
    rst          = 1'b1;
    if1.in_valid = 1'b0;
    if1.a        = '0;
    if1.b        = '0;
    if1.c        = 1'b0;
    if4.in_valid = 1'b0;
    if4.a        = '0;
    if4.b        = '0;
    if4.c        = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    check_cleared("reset");

    // Operands during reset are discarded.
    if1.in_valid = 1'b1;
    if1.a        = 1'b1;
    if1.b        = 1'b1;
    if1.c        = 1'b1;
    tick();
    check_cleared("reset_discard");

    // Release and reapply: 1+1+1 = 3 -> sum 1, cout 1, ovf 0.
    rst = 1'b0;
    q1.push_back('{sum: 4'd1, cout: 1'b1, ovf: 1'b0});
    tick();

    // Exhaustive WIDTH=1, back-to-back.
    for (int i = 0; i < 8; i++) begin
      abc          = 3'(i);
      if1.in_valid = 1'b1;
      if1.a        = abc[2];
      if1.b        = abc[1];
      if1.c        = abc[0];
      q1.push_back('{sum: {3'b0, w1_sum[i]}, cout: w1_cout[i], ovf: w1_ovf[i]});
      tick();
    end

    // Hold: result persists with in_valid low, out_valid drops.
    if1.a = 1'b1;
    if1.b = 1'b0;
    if1.c = 1'b0;
    q1.push_back('{sum: 4'd1, cout: 1'b0, ovf: 1'b0});
    tick();
    if1.in_valid = 1'b0;
    if1.a        = 1'b1;
    if1.b        = 1'b1;
    tick();
    check("hold_sum",   {31'b0, if1.sum},       32'd1);
    check("hold_cout",  {31'b0, if1.cout},      32'd0);
    check("hold_valid", {31'b0, if1.out_valid}, 32'd0);

    // WIDTH=4 wrap and signed overflow, back-to-back.
    for (int i = 0; i < 6; i++) begin
      drive4(v4[i], 1'b1);
      tick();
    end
    if4.in_valid = 1'b0;
    tick();

    // Mid-stream reset on the third operand set.
    drive4(ms[0], 1'b1);
    tick();
    drive4(ms[1], 1'b1);
    tick();
    check("ms_result2_sum", {28'b0, if4.sum}, 32'd9);
    rst = 1'b1;
    drive4(ms[2], 1'b0);
    tick();
    check("ms_clear_sum",   {28'b0, if4.sum},       32'd0);
    check("ms_clear_cout",  {31'b0, if4.cout},      32'd0);
    check("ms_clear_ovf",   {31'b0, if4.ovf},       32'd0);
    check("ms_clear_valid", {31'b0, if4.out_valid}, 32'd0);
    rst = 1'b0;
    drive4(ms[3], 1'b1);
    tick();
    drive4(ms[4], 1'b1);
    tick();
    if4.in_valid = 1'b0;
    tick();
    tick();

    // Every expected result must have been presented.
    check("w1_pending", q1.size(), 32'd0);
    check("w4_pending", q4.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
